issue_sequencer: RTL and testbench

Sequences decoded instruction words from fetch into the execution side. Holds fetched 32-bit words in a small queue and splits each into a 4-bit opcode (bits 3:0) and 28-bit operand field (bits 31:4). Classifies the opcode to a target unit and issues one instruction at a time over a valid/ready handshake. Stalls on memory loads, flushes the queue on jumps, and drives the bus lock for `lock`. Sits between the fetch stage and the unit dispatch muxes, directly behind `decoder`.

---
 rtl/isa_pkg.sv | 35 +++
 rtl/iss_fifo.sv | 43 ++++
 rtl/issue_sequencer.sv | 94 +++++++++
 tb/tb_issue_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: opcode/unit encodings and field widths shared by the issue path
package isa_pkg;
    localparam int OPC_W  = 4;
    localparam int OPND_W = 28;
    typedef enum logic [OPC_W-1:0] {
        OPC_PUSH      = 4'h0,
        OPC_POP       = 4'h1,
        OPC_UNARY     = 4'h2,
        OPC_BINARY    = 4'h3,
        OPC_MOV       = 4'h4,
        OPC_BLVEC     = 4'h5,
        OPC_LODI      = 4'h6,
        OPC_LMEM      = 4'h7,
        OPC_LMEM_BASE = 4'h8,
        OPC_JMP       = 4'h9,
        OPC_JMP_BASE  = 4'hA,
        OPC_MNEMONIC  = 4'hB,
        OPC_LOCK      = 4'hC
    } opc_e;
    localparam logic [OPC_W-1:0] OPC_ILL_MIN = 4'hD;
    typedef enum logic [2:0] {
        UNIT_STACK  = 3'd0,
        UNIT_ALU    = 3'd1,
        UNIT_MEM    = 3'd2,
        UNIT_BRANCH = 3'd3,
        UNIT_MISC   = 3'd4
    } unit_e;
    // opcodes are grouped in contiguous ranges, so classification is a range ladder
    function automatic unit_e opc_to_unit(input logic [OPC_W-1:0] opc);
        return opc <= OPC_POP       ? UNIT_STACK  :
               opc <= OPC_LODI      ? UNIT_ALU    :
               opc <= OPC_LMEM_BASE ? UNIT_MEM    :
               opc <= OPC_JMP_BASE  ? UNIT_BRANCH : UNIT_MISC;
    endfunction
endpackage

// File: rtl/iss_fifo.sv
// iss_fifo: DEPTH x 32 circular queue with full/empty flags and synchronous clear
module iss_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    assign full  = cnt_q == FULL_CNT;
    assign empty = cnt_q == '0;
    assign rdata = mem_q[rd_q];
    // storage is zeroed on reset so the issue fields read 0 out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !full) begin
            mem_q[wr_q] <= wdata;
        end
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push && !full);
            rd_q  <= rd_q + AW'(pop && !empty);
            cnt_q <= cnt_q + (AW+1)'(push && !full) - (AW+1)'(pop && !empty);
        end
    end
endmodule

// File: rtl/issue_sequencer.sv
// issue_sequencer: queues fetch words and issues them one at a time; ISSUE_SEQ_PERF_EN adds perf counters
module issue_sequencer
    import isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_word,
    output logic              in_ready,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [OPC_W-1:0]  iss_opc,
    output logic [OPND_W-1:0] iss_operands,
    output logic [2:0]        iss_unit,
    output logic              iss_illegal,
    input  logic              mem_done,
    output logic              flush,
    output logic              bus_lock,
`ifdef ISSUE_SEQ_PERF_EN
    output logic [CNT_W-1:0]  perf_issued,
    output logic [CNT_W-1:0]  perf_stall,
`endif
    output logic [7:0]        illegal_cnt
);
    typedef enum logic [1:0] {S_ISSUE, S_WAIT_MEM, S_FLUSH} state_e;
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
    state_e      state_q;
    logic        lock_q;
    logic [7:0]  ill_q;
    logic [31:0] head;
    logic        full, empty, xfer;
    unit_e       unit;
    assign in_ready     = !full && state_q != S_FLUSH;
    assign iss_valid    = state_q == S_ISSUE && !empty;
    assign xfer         = iss_valid && iss_ready;
    assign iss_opc      = head[OPC_W-1:0];
    assign iss_operands = head[31:OPC_W];
    assign unit         = opc_to_unit(iss_opc);
    assign iss_unit     = unit;
    assign iss_illegal  = iss_opc >= OPC_ILL_MIN;
    assign flush        = state_q == S_FLUSH;
    assign bus_lock     = lock_q;
    assign illegal_cnt  = ill_q;
    iss_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (in_valid && in_ready),
        .pop   (xfer),
        .wdata (in_word),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
    // issue FSM, bus lock and saturating illegal-opcode count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ISSUE;
            lock_q  <= 1'b0;
            ill_q   <= '0;
        end else begin
            if (state_q == S_ISSUE && xfer)
                state_q <= unit == UNIT_MEM ? S_WAIT_MEM : unit == UNIT_BRANCH ? S_FLUSH : S_ISSUE;
            else if (state_q == S_FLUSH || (state_q == S_WAIT_MEM && mem_done))
                state_q <= S_ISSUE;
            if (xfer && iss_opc == OPC_LOCK)
                lock_q <= 1'b1;
            else if (state_q == S_WAIT_MEM && mem_done)
                lock_q <= 1'b0;
            if (xfer && iss_illegal && ill_q != 8'hFF)
                ill_q <= ill_q + 8'd1;
        end
    end
`ifdef ISSUE_SEQ_PERF_EN
    logic [CNT_W-1:0] issued_q, stall_q;
    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
    // free-running wrap-around counters of transfers and stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_q + CNT_W'(xfer);
            stall_q  <= stall_q + CNT_W'((iss_valid && !iss_ready) || state_q == S_WAIT_MEM);
        end
    end
`endif
endmodule

// File: tb/tb_issue_sequencer.sv
// tb_issue_sequencer: random and directed stimulus checked against a queue-based reference model
module tb_issue_sequencer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    logic        clk = 1'b0;
    logic        rst, in_valid, iss_ready, mem_done;
    logic [31:0] in_word;
    logic        in_ready, iss_valid, iss_illegal, flush, bus_lock;
    logic [3:0]  iss_opc;
    logic [27:0] iss_operands;
    logic [2:0]  iss_unit;
    logic [7:0]  illegal_cnt;
`ifdef ISSUE_SEQ_PERF_EN
    logic [CNT_W-1:0] perf_issued, perf_stall;
`endif
    int total = 0;
    int bad = 0;
    logic [31:0] q[$];
    bit  wm, fl, lk;
    int  ill, pi, ps;

    always #5 clk = ~clk;

    issue_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_word      (in_word),
        .in_ready     (in_ready),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_opc      (iss_opc),
        .iss_operands (iss_operands),
        .iss_unit     (iss_unit),
        .iss_illegal  (iss_illegal),
        .mem_done     (mem_done),
        .flush        (flush),
        .bus_lock     (bus_lock),
`ifdef ISSUE_SEQ_PERF_EN
        .perf_issued  (perf_issued),
        .perf_stall   (perf_stall),
`endif
        .illegal_cnt  (illegal_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_unit(input int o);
        if (o < 2) return 0;
        if (o < 7) return 1;
        if (o < 9) return 2;
        if (o < 11) return 3;
        return 4;
    endfunction

    function automatic logic [31:0] mkw(input int opc);
        logic [27:0] r;
        r = 28'($urandom);
        return {r, 4'(opc)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_word = '0; iss_ready = 1'b0; mem_done = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_opc", iss_opc, 0);
        chk("rst_operands", iss_operands, 0);
        chk("rst_unit", iss_unit, 0);
        chk("rst_illegal", iss_illegal, 0);
        chk("rst_flush", flush, 0);
        chk("rst_bus_lock", bus_lock, 0);
        chk("rst_illegal_cnt", illegal_cnt, 0);
`ifdef ISSUE_SEQ_PERF_EN
        chk("rst_perf_issued", perf_issued, 0);
        chk("rst_perf_stall", perf_stall, 0);
`endif
        rst = 1'b0;
        q.delete();
        wm = 0; fl = 0; lk = 0; ill = 0; pi = 0; ps = 0;
    endtask

    // one clock: drive inputs, compare outputs with the model, then advance the model
    task automatic cyc(input bit v, input logic [31:0] w, input bit r, input bit md);
        bit er, ev, xf;
        logic [31:0] h;
        int u;
        @(negedge clk);
        in_valid = v; in_word = w; iss_ready = r; mem_done = md;
        #1;
        er = !fl && q.size() < DEPTH;
        ev = !fl && !wm && q.size() > 0;
        chk("in_ready", in_ready, er);
        chk("iss_valid", iss_valid, ev);
        chk("flush", flush, fl);
        chk("bus_lock", bus_lock, lk);
        chk("illegal_cnt", illegal_cnt, ill);
        if (ev) begin
            h = q[0];
            chk("iss_opc", iss_opc, h[3:0]);
            chk("iss_operands", iss_operands, h[31:4]);
            chk("iss_unit", iss_unit, ref_unit(int'(h[3:0])));
            chk("iss_illegal", iss_illegal, h[3:0] >= 4'hD);
        end
`ifdef ISSUE_SEQ_PERF_EN
        chk("perf_issued", perf_issued, pi);
        chk("perf_stall", perf_stall, ps);
`endif
        xf = ev && r;
        if ((ev && !r) || wm) ps = (ps + 1) % (1 << CNT_W);
        if (fl) begin
            q.delete();
            fl = 0;
        end else begin
            if (wm && md) begin
                wm = 0;
                lk = 0;
            end
            if (xf) begin
                h = q.pop_front();
                pi = (pi + 1) % (1 << CNT_W);
                u = ref_unit(int'(h[3:0]));
                if (u == 2) wm = 1;
                if (u == 3) fl = 1;
                if (h[3:0] == 4'hC) lk = 1;
                if (h[3:0] >= 4'hD && ill < 255) ill++;
            end
            if (v && er) q.push_back(w);
        end
    endtask

    initial begin
        do_reset();
        cyc(1, 32'h0000_0013, 0, 0);
        cyc(0, '0, 0, 0);
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) cyc(1, mkw(2 + i % 5), 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0);
        cyc(1, mkw(7), 0, 0);
        cyc(1, mkw(2), 0, 0);
        cyc(1, mkw(3), 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
        cyc(1, mkw(9), 0, 0);
        cyc(1, mkw(2), 0, 0);
        cyc(1, mkw(3), 1, 0);
        cyc(1, mkw(4), 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
        cyc(1, mkw(12), 1, 0);
        cyc(1, mkw(8), 1, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 1);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        for (int i = 0; i < 262; i++) cyc(1, mkw(14), 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0);
        cyc(1, mkw(12), 1, 0);
        cyc(1, mkw(7), 1, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        do_reset();
        for (int i = 0; i < 3000; i++)
            cyc($urandom % 4 != 0, $urandom, $urandom % 3 != 0, $urandom % 4 == 0);
        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
